// File: rtl/pipe_if_pkg.sv
// Shared types and constants for the instruction-fetch block.
// IF_FETCH_ERR_EN widens each prefetch entry with a fault bit.
package pipe_if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } if_state_e;

  localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;

`ifdef IF_FETCH_ERR_EN
  localparam int ENTRY_W = 65;
`else
  localparam int ENTRY_W = 64;
`endif

  // The add wraps modulo 2^32, so 32'hFFFFFFFC + 4 gives 0.
  function automatic logic [31:0] pc_add(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/pipe_if_fifo.sv
// Prefetch FIFO between fetch and decode. Flush beats push and pop;
// the head reads as zero while the FIFO is empty.
module pipe_if_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           head_data,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop, full;

  assign full = (count_q == (AW+1)'(DEPTH));

  always_comb begin
    do_pop   = pop & ~flush & (count_q != '0);
    do_push  = push & ~flush & (~full | do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible unless count says so.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;

endmodule

// File: rtl/pipe_if_fetch.sv
// Instruction-fetch control: one outstanding imem fetch, prefetch FIFO to decode,
// redirect flush/squash. IF_FETCH_ERR_EN adds imem_err/id_fault and the HALT state.
module pipe_if_fetch
  import pipe_if_pkg::*;
#(
  parameter int          DEPTH   = 2,
  parameter logic [31:0] PC_STEP = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] pc,
  output logic [31:0] npc,
  output logic        install,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
`ifdef IF_FETCH_ERR_EN
  input  logic        imem_err,
  output logic        id_fault,
`endif
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  if_state_e          state_q, state_d;
  logic [CW-1:0]      fifo_count;
  logic               fifo_room;
  logic               fifo_push;
  logic               ack_err;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;

  assign fifo_room = (fifo_count != CW'(DEPTH));

`ifdef IF_FETCH_ERR_EN
  assign ack_err    = imem_err;
  assign push_entry = {imem_err, pc, imem_rdata};
  assign id_fault   = head_entry[64];
`else
  assign ack_err    = 1'b0;
  assign push_entry = {pc, imem_rdata};
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!redirect && fifo_room) state_d = WAIT;
      WAIT: begin
        if (imem_ack)      state_d = (!redirect && ack_err) ? HALT : IDLE;
        else if (redirect) state_d = DRAIN;
      end
      DRAIN: if (imem_ack) state_d = IDLE;
`ifdef IF_FETCH_ERR_EN
      HALT:  if (redirect) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // The request in WAIT stays up through a redirect so the memory handshake
  // completes; its data is dropped and DRAIN absorbs a late ack.
  always_comb begin
    imem_req  = 1'b0;
    install   = 1'b0;
    fifo_push = 1'b0;
    npc       = pc_add(pc, PC_STEP);
    case (state_q)
      IDLE: imem_req = !redirect && fifo_room;
      WAIT: begin
        imem_req = 1'b1;
        if (imem_ack && !redirect) begin
          fifo_push = 1'b1;
          install   = 1'b1;
        end
      end
      default: ;
    endcase
    if (redirect) begin
      install = 1'b1;
      npc     = redirect_pc;
    end
    if (clr) begin
      imem_req  = 1'b0;
      install   = 1'b0;
      fifo_push = 1'b0;
    end
  end

  assign imem_addr = pc;

  pipe_if_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (clr),
    .push       (fifo_push),
    .push_data  (push_entry),
    .pop        (id_valid & id_ready),
    .flush      (redirect),
    .head_data  (head_entry),
    .head_valid (id_valid),
    .count      (fifo_count)
  );

  assign id_inst = head_entry[31:0];
  assign id_pc   = head_entry[63:32];

endmodule

// File: tb/tb_pipe_if_fetch.sv
// Randomized bench for pipe_if_fetch with a transaction-level fetch model,
// an emulated PC register and memory, and a scoreboard on the decode side.
module tb_pipe_if_fetch;
  import pipe_if_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] pc = '0, npc, imem_addr, imem_rdata = '0, redirect_pc = '0;
  logic [31:0] id_inst, id_pc;
  logic        install, imem_req, imem_ack = 1'b0, redirect = 1'b0;
  logic        id_valid, id_ready = 1'b0;
`ifdef IF_FETCH_ERR_EN
  logic        imem_err = 1'b0;
  logic        id_fault;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q[$];

  bit          m_live, m_dead, popped;
  logic [31:0] m_pc;
  bit          s_install;
  logic [31:0] s_npc;

  bit          mem_busy;
  int          mem_lat;
  int          lat_max   = 0;
  int          redir_pct = 0;
  int          ready_pct = 100;
  bit          force_redir;
  logic [31:0] force_pc;

  always #5 clk = ~clk;

  pipe_if_fetch #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .clr         (clr),
    .pc          (pc),
    .npc         (npc),
    .install     (install),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
`ifdef IF_FETCH_ERR_EN
    .imem_err    (imem_err),
    .id_fault    (id_fault),
`endif
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_inst     (id_inst),
    .id_pc       (id_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the decode-side head against the scoreboard and pops on accept.
  always @(negedge clk) begin
    popped = 1'b0;
    if (!clr) begin
      chk("id_valid", {31'd0, id_valid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        chk("id_pc", id_pc, exp_q[0][63:32]);
        chk("id_inst", id_inst, exp_q[0][31:0]);
        if (id_ready) begin
          void'(exp_q.pop_front());
          popped = 1'b1;
        end
      end else begin
        chk("id_pc_empty", id_pc, 32'd0);
        chk("id_inst_empty", id_inst, 32'd0);
      end
    end
  end

  // Reference model: one fetch in flight (live or squashed), expected PC stream,
  // expected FIFO contents in exp_q.
  always @(negedge clk) begin
    int cnt;
    #1;
    if (!clr) begin
      cnt = exp_q.size() + int'(popped);
      if (redirect) begin
        chk("redir_install", {31'd0, install}, 32'd1);
        chk("redir_npc", npc, redirect_pc);
        chk("redir_req", {31'd0, imem_req}, {31'd0, m_live});
        if (m_live) begin
          m_live = 1'b0;
          m_dead = !imem_ack;
        end else if (m_dead && imem_ack) begin
          m_dead = 1'b0;
        end
        exp_q.delete();
        m_pc = redirect_pc;
      end else if (m_live) begin
        chk("wait_req", {31'd0, imem_req}, 32'd1);
        chk("wait_addr", imem_addr, m_pc);
        if (imem_ack) begin
          chk("ack_install", {31'd0, install}, 32'd1);
          chk("ack_npc", npc, m_pc + 32'd4);
          exp_q.push_back({m_pc, imem_rdata});
          m_pc   = m_pc + 32'd4;
          m_live = 1'b0;
        end else begin
          chk("wait_install", {31'd0, install}, 32'd0);
        end
      end else if (m_dead) begin
        chk("drain_req", {31'd0, imem_req}, 32'd0);
        chk("drain_install", {31'd0, install}, 32'd0);
        if (imem_ack) m_dead = 1'b0;
      end else begin
        chk("idle_install", {31'd0, install}, 32'd0);
        chk("idle_req", {31'd0, imem_req}, {31'd0, cnt < DEPTH});
        if (cnt < DEPTH) begin
          chk("issue_addr", imem_addr, m_pc);
          m_live = 1'b1;
        end
      end
      s_install = install;
      s_npc     = npc;
    end
  end

  task automatic mem_sample();
    if (!mem_busy && imem_req && !imem_ack) begin
      mem_busy = 1'b1;
      mem_lat  = $urandom_range(lat_max);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (s_install) pc = s_npc;
    imem_ack = 1'b0;
    if (mem_busy) begin
      if (mem_lat == 0) begin
        imem_ack = 1'b1;
        mem_busy = 1'b0;
      end else begin
        mem_lat--;
      end
    end
    imem_rdata = $urandom;
    redirect   = ($urandom_range(99) < redir_pct);
    case ($urandom_range(3))
      0:       redirect_pc = 32'h0000_0400;
      1:       redirect_pc = 32'hFFFF_FFFC;
      2:       redirect_pc = 32'h0000_0100;
      default: redirect_pc = $urandom & 32'hFFFF_FFFC;
    endcase
    if (force_redir) begin
      redirect    = 1'b1;
      redirect_pc = force_pc;
      force_redir = 1'b0;
    end
    id_ready = ($urandom_range(99) < ready_pct);
    @(negedge clk);
    mem_sample();
  endtask

  task automatic do_reset();
    clr = 1'b1;
    redirect = 1'b0; imem_ack = 1'b0; id_ready = 1'b0;
    pc = '0; mem_busy = 1'b0; m_live = 1'b0; m_dead = 1'b0; m_pc = '0;
    exp_q.delete(); s_install = 1'b0;
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_install", {31'd0, install}, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    mem_sample();
  endtask

  initial begin
    bit found;
    do_reset();

    // Sequential stream from 0x100, single-cycle memory, decode always ready.
    force_redir = 1'b1; force_pc = 32'h100;
    redir_pct = 0; ready_pct = 100; lat_max = 0;
    repeat (14) step();

    // Decode stalls: the FIFO fills and requests stop.
    ready_pct = 0;
    repeat (12) step();
    chk("full_req", {31'd0, imem_req}, 32'd0);
    chk("full_valid", {31'd0, id_valid}, 32'd1);
    ready_pct = 100;
    repeat (6) step();

    // Wrap-around fetch across 0xFFFFFFFC.
    force_redir = 1'b1; force_pc = 32'hFFFF_FFFC;
    repeat (8) step();

    // Random mix of latencies, stalls and redirects.
    redir_pct = 8; ready_pct = 60; lat_max = 3;
    repeat (3000) step();

    // Reset asserted while a fetch is outstanding.
    redir_pct = 0; found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      #2;
      if (m_live && !imem_ack && !redirect && mem_busy) found = 1'b1;
    end
    chk("mid_wait_found", {31'd0, found}, 32'd1);
    do_reset();
    redir_pct = 8; ready_pct = 70; lat_max = 2;
    repeat (60) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
